// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, types and helpers for the quarter-phase blocks.
// Phase scale: 2^PH_W LSB = 90 degrees.
package cordic_pkg;

  localparam int MAX_ITER = 19;
  localparam int PH_W     = 23;
  localparam int XY_W     = 21;
  // Phase accumulator: sign bit plus one guard bit above 90 degrees.
  localparam int ACC_W    = PH_W + 2;

  localparam logic [15:0] CORDIC_GAIN_INV = 16'hDBD9;

  // atan(2^-(i+1)) scaled so that 2^23 = 90 degrees.
  localparam logic [PH_W-1:0] ANGLE [MAX_ITER] = '{
    23'h25C80A, 23'h13F671, 23'h0A2224, 23'h05161B, 23'h028BB0,
    23'h0145EC, 23'h00A2F9, 23'h00517D, 23'h0028BE, 23'h00145F,
    23'h000A30, 23'h000518, 23'h00028C, 23'h000146, 23'h0000A3,
    23'h000051, 23'h000029, 23'h000014, 23'h00000A
  };

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  // Place a 16-bit unsigned component into the signed working format
  // {sign, 2 growth bits, value, 2 fraction bits}.
  function automatic logic signed [XY_W-1:0] to_xy(input logic [15:0] v);
    return {3'b000, v, 2'b00};
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring-mode micro-rotation: drives y towards zero and accumulates
// the rotated angle. Purely combinational so it can be replicated per stage.
module cordic_vec_step
  import cordic_pkg::*;
(
  input  logic signed [XY_W-1:0]  x,
  input  logic signed [XY_W-1:0]  y,
  input  logic signed [ACC_W-1:0] p,
  input  logic        [4:0]       shift,
  input  logic        [PH_W-1:0]  angle,
  output logic signed [XY_W-1:0]  x_next,
  output logic signed [XY_W-1:0]  y_next,
  output logic signed [ACC_W-1:0] p_next
);

  logic signed [XY_W-1:0]  x_sh;
  logic signed [XY_W-1:0]  y_sh;
  logic signed [ACC_W-1:0] ang;

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    x_sh = x >>> shift;
    y_sh = y >>> shift;
    ang  = signed'({2'b00, angle});
    if (!y[XY_W-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      p_next = p + ang;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      p_next = p - ang;
    end
  end

endmodule

// File: rtl/cordic_vec.sv
// Iterative vectoring CORDIC: first-quadrant (x, y) -> quarter phase and
// magnitude, one micro-rotation per clock, valid/ready on both sides.
module cordic_vec
  import cordic_pkg::*;
#(
  parameter int N_ITER = 19
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [15:0] o_qph,
  output logic [16:0] o_mag,
  output logic        o_valid,
  input  logic        i_ready
);

  localparam logic signed [ACC_W-1:0] P_90 = {2'b01, {PH_W{1'b0}}};

  state_t                  state;
  logic [4:0]              cnt;
  logic signed [XY_W-1:0]  x_q;
  logic signed [XY_W-1:0]  y_q;
  logic signed [ACC_W-1:0] p_q;
  logic                    zero_q;

  logic signed [XY_W-1:0]  x_nx;
  logic signed [XY_W-1:0]  y_nx;
  logic signed [ACC_W-1:0] p_nx;
  logic [4:0]              shift;
  logic [33:0]             mag_prod;
  logic [15:0]             qph_sat;

  assign shift = cnt + 5'd1;

  cordic_vec_step u_step (
    .x      (x_q),
    .y      (y_q),
    .p      (p_q),
    .shift  (shift),
    .angle  (ANGLE[cnt]),
    .x_next (x_nx),
    .y_next (y_nx),
    .p_next (p_nx)
  );

  // x is non-negative after the iterations, so its integer part is unsigned.
  assign mag_prod = {16'b0, x_q[XY_W-2:2]} * {18'b0, CORDIC_GAIN_INV};

  always_comb begin
    if (p_q[ACC_W-1])   qph_sat = '0;
    else if (p_q[PH_W]) qph_sat = 16'hFFFF;
    else                qph_sat = p_q[PH_W-1:7];
  end

  // Ready is gated by reset directly so it drops in the same cycle reset is asserted.
  assign o_ready = i_rst_n && (state == IDLE);

  // NOTE: all state here is non-blocking so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      zero_q  <= 1'b0;
      o_qph   <= '0;
      o_mag   <= '0;
      o_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            cnt    <= '0;
            zero_q <= (i_x == 16'd0) && (i_y == 16'd0);
            state  <= ITER;
            // Steep vectors are rotated by -90 degrees so the iterations only
            // ever have to cover +/-45 degrees.
            if (i_y > i_x) begin
              x_q <= to_xy(i_y);
              y_q <= -to_xy(i_x);
              p_q <= P_90;
            end else begin
              x_q <= to_xy(i_x);
              y_q <= to_xy(i_y);
              p_q <= '0;
            end
          end
        end
        ITER: begin
          x_q <= x_nx;
          y_q <= y_nx;
          p_q <= p_nx;
          if (cnt == 5'(N_ITER - 1)) state <= SCALE;
          else                       cnt   <= cnt + 5'd1;
        end
        SCALE: begin
          o_valid <= 1'b1;
          o_qph   <= zero_q ? 16'd0 : qph_sat;
          o_mag   <= zero_q ? 17'd0 : mag_prod[32:16];
          state   <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vec.sv
// Self-checking bench for cordic_vec: directed corner vectors, handshake,
// mid-operation reset and random vectors against an atan2/sqrt reference.
module tb_cordic_vec;

  localparam real PI  = 3.14159265358979;
  localparam int  LAT = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] qph;
  logic [16:0] mag;
  logic        valid_out;
  logic        ready_in;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  cordic_vec #(.N_ITER(19)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_x     (x_in),
    .i_y     (y_in),
    .i_valid (valid_in),
    .o_ready (ready_out),
    .o_qph   (qph),
    .o_mag   (mag),
    .o_valid (valid_out),
    .i_ready (ready_in)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input real exp, input real tol);
    real d;
    d = real'(obs) - exp;
    if (d < 0.0) d = -d;
    n_checks++;
    assert ((d <= tol) === 1'b1) else begin
      n_fails++;
      $error("FAIL %s: observed %0d, expected %0.2f +/- %0.2f", tag, obs, exp, tol);
    end
  endtask

  // Reference: ideal angle and length of the input vector.
  function automatic real ref_qph(input int x, input int y);
    real q;
    if (x == 0 && y == 0) return 0.0;
    q = $atan2(real'(y), real'(x)) / (PI / 2.0) * 65536.0;
    if (q > 65535.0) q = 65535.0;
    return q;
  endfunction

  function automatic real ref_mag(input int x, input int y);
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (ready_out !== 1'b1 && w < 50) begin
      tick;
      w++;
    end
    check({tag, "_ready_idle"}, ready_out, 1);
  endtask

  // Offer one vector, then count edges until o_valid rises.
  task automatic run_vec(input string tag, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] q, output logic [16:0] m);
    int lat = -1;
    wait_ready(tag);
    x_in     = x;
    y_in     = y;
    valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    check({tag, "_ready_busy"}, ready_out, 0);
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (valid_out === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, LAT);
    q = qph;
    m = mag;
  endtask

  task automatic consume(input string tag);
    ready_in = 1'b1;
    tick;
    ready_in = 1'b0;
    check({tag, "_valid_drop"}, valid_out, 0);
  endtask

  task automatic check_result(input string tag, input int x, input int y,
                              input logic [15:0] q, input logic [16:0] m);
    real rm;
    rm = ref_mag(x, y);
    if (x == 0 && y == 0) begin
      check({tag, "_qph"}, q, 0);
      check({tag, "_mag"}, m, 0);
    end else begin
      check_tol({tag, "_qph"}, int'(q), ref_qph(x, y), 3.0);
      check_tol({tag, "_mag"}, int'(m), rm, 3.0 + rm * 1.0e-4);
    end
  endtask

  task automatic do_vec(input string tag, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] q;
    logic [16:0] m;
    run_vec(tag, x, y, q, m);
    check_result(tag, int'(x), int'(y), q, m);
    consume(tag);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      tick;
      if (valid_out !== 1'b0) seen++;
    end
    check({tag, "_no_output"}, seen, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q0;
    logic [16:0] m0;
    logic [15:0] rx;
    logic [15:0] ry;
    int unstable;
    int busy;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    x_in     = '0;
    y_in     = '0;
    repeat (3) tick;
    check("rst_valid", valid_out, 0);
    check("rst_qph", qph, 0);
    check("rst_mag", mag, 0);
    check("rst_ready", ready_out, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", ready_out, 1);

    do_vec("x_axis", 16'hFFFF, 16'h0000);
    do_vec("y_axis", 16'h0000, 16'hFFFF);
    do_vec("diag", 16'h8000, 16'h8000);
    do_vec("deg30", 16'hDDB3, 16'h8000);
    do_vec("zero", 16'h0000, 16'h0000);

    // Backpressure: result must hold and new requests must be ignored.
    run_vec("bp", 16'h8000, 16'h4000, q0, m0);
    check_result("bp", 32'h8000, 32'h4000, q0, m0);
    x_in     = 16'h1234;
    y_in     = 16'h5678;
    valid_in = 1'b1;
    unstable = 0;
    busy     = 0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (valid_out !== 1'b1 || qph !== q0 || mag !== m0) unstable++;
      if (ready_out !== 1'b0) busy++;
    end
    check("bp_hold", unstable, 0);
    check("bp_ready_low", busy, 0);
    valid_in = 1'b0;
    consume("bp");
    check("bp_ready_back", ready_out, 1);
    watch_idle("bp", 25);

    // Reset while the counter sits at 7.
    wait_ready("mid_rst");
    x_in     = 16'h9000;
    y_in     = 16'h3000;
    valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    repeat (7) tick;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready_low", ready_out, 0);
    tick;
    check("mid_rst_valid", valid_out, 0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready_idle", ready_out, 1);
    watch_idle("mid_rst", 30);
    do_vec("after_rst", 16'h4000, 16'h0000);

    for (int n = 0; n < 8; n++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 16'($urandom_range(0, 65535));
      if (rx < 16'h8000 && ry < 16'h8000) begin
        if (n % 2 == 0) rx = rx | 16'h8000;
        else            ry = ry | 16'h8000;
      end
      do_vec($sformatf("rand%0d", n), rx, ry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
